// File: rtl/multi_color_edge_merge.sv
// multi_color_edge_merge: per-color windowed mask count gated by the edge bit.
// Streams raster pixels through line buffers, column sums and running row sums.
module multi_color_edge_merge #(
  parameter int WIDTH       = 640,
  parameter int HEIGHT      = 480,
  parameter int COLORS      = 2,
  parameter int M_SIZE      = 11,
  parameter int M_THRESHOLD = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [COLORS-1:0]         color_mask,
  input  logic                      edge_in,
  output logic                      out_valid,
  output logic [COLORS-1:0]         edge_color,
  output logic                      edge_out,
  output logic [$clog2(HEIGHT)-1:0] out_row,
  output logic [$clog2(WIDTH)-1:0]  out_col,
  output logic                      out_eof
);
  localparam int R  = (M_SIZE - 1) / 2;
  localparam int D  = R * WIDTH + R;
  localparam int LB = 2 * R * WIDTH;
  localparam int HW = 2 * R + 1;
  localparam int RW = $clog2(HEIGHT);
  localparam int XW = $clog2(WIDTH);
  localparam int SW = $clog2(HEIGHT + R + 1);
  localparam int CW = $clog2(M_SIZE * M_SIZE + 1);

  localparam logic [XW-1:0] COL_LAST  = XW'(WIDTH - 1);
  localparam logic [XW-1:0] COL_RM1   = XW'(R - 1);
  localparam logic [SW-1:0] ROW_R     = SW'(R);
  localparam logic [SW-1:0] ROW_LAST  = SW'(HEIGHT - 1);
  localparam logic [SW-1:0] ROW_FLUSH = SW'(HEIGHT + R);
  localparam logic [RW-1:0] OROW_LAST = RW'(HEIGHT - 1);

  typedef enum logic [1:0] {FILL, STREAM, FLUSH} state_t;

  state_t          state, state_n;
  logic            ready_q, ready_n;
  logic            fire, emit;
  logic [COLORS:0] pix;
  logic [SW-1:0]   src_row;
  logic [XW-1:0]   src_col;
  logic [RW-1:0]   orow;
  logic [XW-1:0]   ocol;
  logic            fill_done, frame_done, flush_done;
  logic            last_col, last_out;

  logic [COLORS:0] lb     [LB];
  logic [CW-1:0]   vq     [COLORS][HW];
  logic [CW-1:0]   hsum   [COLORS];
  logic [CW-1:0]   tail   [COLORS];
  logic [CW-1:0]   vsum   [COLORS];
  logic [CW-1:0]   hsum_n [COLORS];
  logic [CW-1:0]   tail_n [COLORS];
  logic [CW-1:0]   wsum   [COLORS];

  logic            s1_valid, s1_edge, s1_eof;
  logic [CW-1:0]   s1_cnt [COLORS];
  logic [RW-1:0]   s1_row;
  logic [XW-1:0]   s1_col;

  assign in_ready   = ready_q;
  assign fire       = (state == FLUSH) | (in_valid & ready_q);
  assign emit       = fire & (state != FILL);
  assign pix        = (state == FLUSH) ? '0 : {edge_in, color_mask};
  assign last_col   = (src_col == COL_LAST);
  assign fill_done  = (src_row == ROW_R) && (src_col == COL_RM1);
  assign frame_done = (src_row == ROW_LAST) && last_col;
  assign flush_done = (src_row == ROW_FLUSH) && (src_col == COL_RM1);
  assign last_out   = (orow == OROW_LAST) && (ocol == COL_LAST);
  assign edge_out   = |edge_color;

  // Next state; ready is registered from the state being entered
  always_comb begin
    state_n = state;
    if (fire) begin
      unique case (state)
        FILL:    if (fill_done) state_n = STREAM;
        STREAM:  if (frame_done) state_n = FLUSH;
        FLUSH:   if (flush_done) state_n = FILL;
        default: state_n = FILL;
      endcase
    end
    ready_n = (state_n != FLUSH);
  end

  // State and ready registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= FILL;
      ready_q <= 1'b0;
    end else begin
      state   <= state_n;
      ready_q <= ready_n;
    end
  end

  // Column sums, row running sum, and the right-edge draining tail sum
  always_comb begin
    for (int k = 0; k < COLORS; k++) begin
      vsum[k] = CW'(pix[k]);
      for (int i = 1; i <= 2 * R; i++) begin
        if (int'(src_row) >= i)
          vsum[k] = vsum[k] + CW'(lb[i * WIDTH - 1][k]);
      end
      if (src_col == '0)
        hsum_n[k] = vsum[k];
      else if (int'(src_col) >= HW)
        hsum_n[k] = hsum[k] + vsum[k] - vq[k][HW-1];
      else
        hsum_n[k] = hsum[k] + vsum[k];
      if (src_col == '0)
        tail_n[k] = hsum[k] - vq[k][HW-1];
      else
        tail_n[k] = tail[k] - vq[k][HW-1];
      wsum[k] = (int'(src_col) >= R) ? hsum_n[k] : tail_n[k];
    end
  end

  // Source raster position, including flush rows past the frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_row <= '0;
      src_col <= '0;
    end else if (fire) begin
      if (state == FLUSH && flush_done) begin
        src_row <= '0;
        src_col <= '0;
      end else if (last_col) begin
        src_row <= src_row + SW'(1);
        src_col <= '0;
      end else begin
        src_col <= src_col + XW'(1);
      end
    end
  end

  // Output raster position, advanced once per emitted pixel
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      orow <= '0;
      ocol <= '0;
    end else if (emit) begin
      if (last_out) begin
        orow <= '0;
        ocol <= '0;
      end else if (ocol == COL_LAST) begin
        orow <= orow + RW'(1);
        ocol <= '0;
      end else begin
        ocol <= ocol + XW'(1);
      end
    end
  end

  // Accumulators and recent column-sum history
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < COLORS; k++) begin
        hsum[k] <= '0;
        tail[k] <= '0;
        for (int i = 0; i < HW; i++) vq[k][i] <= '0;
      end
    end else if (fire) begin
      for (int k = 0; k < COLORS; k++) begin
        hsum[k]  <= hsum_n[k];
        tail[k]  <= tail_n[k];
        vq[k][0] <= vsum[k];
        for (int i = 1; i < HW; i++) vq[k][i] <= vq[k][i-1];
      end
    end
  end

  // Line storage; stale rows are masked by the source row count
  always_ff @(posedge clk) begin
    if (fire) begin
      lb[0] <= pix;
      for (int i = 1; i < LB; i++) lb[i] <= lb[i-1];
    end
  end

  // Stage 1: capture window counts, center edge and position
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_edge  <= 1'b0;
      s1_eof   <= 1'b0;
      s1_row   <= '0;
      s1_col   <= '0;
      for (int k = 0; k < COLORS; k++) s1_cnt[k] <= '0;
    end else begin
      s1_valid <= emit;
      s1_edge  <= emit & lb[D-1][COLORS];
      s1_eof   <= emit & last_out;
      s1_row   <= emit ? orow : '0;
      s1_col   <= emit ? ocol : '0;
      for (int k = 0; k < COLORS; k++) s1_cnt[k] <= wsum[k];
    end
  end

  // Stage 2: threshold compare and zero-gated outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      edge_color <= '0;
      out_row    <= '0;
      out_col    <= '0;
      out_eof    <= 1'b0;
    end else begin
      out_valid <= s1_valid;
      for (int k = 0; k < COLORS; k++)
        edge_color[k] <= s1_valid & s1_edge &
                         (int'(s1_cnt[k]) >= M_THRESHOLD);
      out_row <= s1_row;
      out_col <= s1_col;
      out_eof <= s1_eof;
    end
  end

endmodule

// File: tb/tb_multi_color_edge_merge.sv
// tb_multi_color_edge_merge: table-driven and random frames against a
// brute-force window-count model, for thresholds 5 and 3.
module tb_multi_color_edge_merge;
  localparam int W = 8;
  localparam int H = 6;
  localparam int N = W * H;
  localparam int C = 2;
  localparam int R = 1;
  localparam int D = R * W + R;
  localparam int NV = 8;

  typedef struct {
    int row;
    int col;
    logic [C-1:0] ec;
    logic eo;
    logic eof;
    int cyc;
  } ev_t;

  typedef struct {
    int pat;
    int gap;
    int thr;
    int r;
    int c;
    logic [C-1:0] ec;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_valid;
  logic [C-1:0] color_mask;
  logic edge_in;
  logic rdy5, rdy3, ov5, ov3, eo5, eo3, eof5, eof3;
  logic [C-1:0] ec5, ec3;
  logic [2:0] row5, row3, col5, col3;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int idle_bad = 0;
  logic [C-1:0] mk [H][W];
  logic eg [H][W];
  int acc [N];
  ev_t q5[$];
  ev_t q3[$];
  vec_t vecs [NV];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  multi_color_edge_merge #(
    .WIDTH(W), .HEIGHT(H), .COLORS(C), .M_SIZE(3), .M_THRESHOLD(5)
  ) dut5 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy5),
    .color_mask(color_mask), .edge_in(edge_in), .out_valid(ov5),
    .edge_color(ec5), .edge_out(eo5), .out_row(row5), .out_col(col5),
    .out_eof(eof5)
  );

  multi_color_edge_merge #(
    .WIDTH(W), .HEIGHT(H), .COLORS(C), .M_SIZE(3), .M_THRESHOLD(3)
  ) dut3 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy3),
    .color_mask(color_mask), .edge_in(edge_in), .out_valid(ov3),
    .edge_color(ec3), .edge_out(eo3), .out_row(row3), .out_col(col3),
    .out_eof(eof3)
  );

  always @(negedge clk) begin
    if (ov5) q5.push_back('{int'(row5), int'(col5), ec5, eo5, eof5, cyc});
    else if (ec5 != 0 || eo5 || row5 != 0 || col5 != 0 || eof5) idle_bad++;
    if (ov3) q3.push_back('{int'(row3), int'(col3), ec3, eo3, eof3, cyc});
    else if (ec3 != 0 || eo3 || row3 != 0 || col3 != 0 || eof3) idle_bad++;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [C-1:0] model_ec(input int r, input int c,
                                            input int thr);
    logic [C-1:0] res;
    res = '0;
    for (int k = 0; k < C; k++) begin
      int cnt;
      cnt = 0;
      for (int dr = -R; dr <= R; dr++)
        for (int dc = -R; dc <= R; dc++)
          if (r + dr >= 0 && r + dr < H && c + dc >= 0 && c + dc < W)
            if (mk[r+dr][c+dc][k]) cnt++;
      res[k] = eg[r][c] && (cnt >= thr);
    end
    return res;
  endfunction

  function automatic int pack(input ev_t e);
    return (e.row << 8) | (e.col << 4) | (int'(e.ec) << 2) |
           (int'(e.eo) << 1) | int'(e.eof);
  endfunction

  function automatic int exp_pack(input int j, input int thr);
    logic [C-1:0] ec;
    ec = model_ec(j / W, j % W, thr);
    return ((j / W) << 8) | ((j % W) << 4) | (int'(ec) << 2) |
           (int'(|ec) << 1) | int'(j == N - 1);
  endfunction

  task automatic fill_pat(input int pat);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        case (pat)
          0: begin mk[r][c] = 2'b01; eg[r][c] = 1'b1; end
          1: begin mk[r][c] = 2'b00; eg[r][c] = 1'b1; end
          2: begin
            mk[r][c] = (c == W - 1) ? 2'b01 : 2'b00;
            eg[r][c] = 1'b1;
          end
          default: begin
            mk[r][c] = 2'($urandom_range(0, 3));
            eg[r][c] = 1'($urandom_range(0, 1));
          end
        endcase
      end
  endtask

  task automatic run_frame(input int gap);
    int p, guard, last, lowcnt, back;
    bit gp;
    q5.delete();
    q3.delete();
    idle_bad = 0;
    p = 0;
    guard = 0;
    gp = 0;
    while (p < N && guard < 2000) begin
      @(negedge clk);
      guard++;
      if (gap != 0 && !gp && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        gp = 1;
      end else begin
        gp = 0;
        in_valid = 1'b1;
        color_mask = mk[p / W][p % W];
        edge_in = eg[p / W][p % W];
        if (rdy5) begin
          acc[p] = cyc;
          p++;
        end
      end
    end
    chk("accepted", p, N);
    last = acc[N-1];
    lowcnt = 0;
    back = -1;
    guard = 0;
    while ((q5.size() < N || q3.size() < N) && guard < 200) begin
      @(negedge clk);
      guard++;
      if (rdy5) begin
        in_valid = 1'b0;
        if (back < 0) back = cyc;
      end else begin
        in_valid = 1'b1;
        color_mask = 2'($urandom_range(0, 3));
        edge_in = 1'b1;
        if (back < 0) lowcnt++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("pulses5", q5.size(), N);
    chk("pulses3", q3.size(), N);
    chk("ready_low_cycles", lowcnt, 9);
    chk("ready_back", back - last, 10);
    chk("idle_zero", idle_bad, 0);
    if (q5.size() >= N) begin
      chk("first_latency", q5[0].cyc - acc[D], 2);
      chk("eof_latency", q5[N-1].cyc - last, 11);
    end
    for (int j = 0; j < N; j++) begin
      if (j < q5.size())
        chk($sformatf("pix5_%0d", j), pack(q5[j]), exp_pack(j, 5));
      if (j < q3.size())
        chk($sformatf("pix3_%0d", j), pack(q3[j]), exp_pack(j, 3));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int idx, got, p;
    vecs[0] = '{0, 0, 5, 0, 0, 2'b00};
    vecs[1] = '{0, 0, 5, 0, 3, 2'b01};
    vecs[2] = '{0, 0, 5, 3, 4, 2'b01};
    vecs[3] = '{0, 0, 5, 5, 7, 2'b00};
    vecs[4] = '{1, 0, 5, 5, 7, 2'b00};
    vecs[5] = '{2, 0, 3, 2, 6, 2'b01};
    vecs[6] = '{2, 0, 3, 2, 0, 2'b00};
    vecs[7] = '{0, 1, 5, 2, 0, 2'b01};
    in_valid = 1'b0;
    color_mask = '0;
    edge_in = 1'b0;
    #1 reset = 1'b1;
    #2;
    chk("rst_ready", int'(rdy5), 0);
    chk("rst_valid", int'(ov5), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1 chk("ready_before_edge", int'(rdy5), 0);
    @(posedge clk);
    #1 chk("ready_after_edge", int'(rdy5), 1);

    for (int v = 0; v < NV; v++) begin
      fill_pat(vecs[v].pat);
      run_frame(vecs[v].gap);
      idx = vecs[v].r * W + vecs[v].c;
      if (vecs[v].thr == 3) got = (q3.size() > idx) ? int'(q3[idx].ec) : -1;
      else got = (q5.size() > idx) ? int'(q5[idx].ec) : -1;
      chk($sformatf("vec%0d_ec", v), got, int'(vecs[v].ec));
    end

    for (int f = 0; f < 3; f++) begin
      fill_pat(3);
      run_frame(f % 2);
    end

    fill_pat(3);
    p = 0;
    while (p < 20) begin
      @(negedge clk);
      in_valid = 1'b1;
      color_mask = mk[p / W][p % W];
      edge_in = eg[p / W][p % W];
      if (rdy5) p++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_rst_valid", int'(ov5), 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_ready", int'(rdy5), 0);
    chk("mid_rst_valid", int'(ov5), 0);
    chk("mid_rst_outs", int'({row5, col5, ec5, eo5, eof5}), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1 chk("mid_rst_ready_back", int'(rdy5), 1);
    fill_pat(0);
    run_frame(0);
    if (q5.size() >= N) begin
      chk("after_rst_corner", int'(q5[0].ec), 0);
      chk("after_rst_border", int'(q5[1].ec), 1);
      chk("after_rst_inner", int'(q5[W + 1].ec), 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_color_edge_merge.md
MULTI_COLOR_EDGE_MERGE -- requirements
Module: multi_color_edge_merge

Interface
REQ-001 SHALL have parameter WIDTH, default 640, active pixels per line.
REQ-002 SHALL have parameter HEIGHT, default 480, active lines per frame.
REQ-003 SHALL have parameter COLORS, default 2, number of independent color-mask channels.
REQ-004 SHALL have parameter M_SIZE, default 11, odd merge-window edge length; R = (M_SIZE-1)/2.
REQ-005 SHALL have parameter M_THRESHOLD, default 5, minimum same-color count in window for a merge hit.
REQ-006 SHALL have port clk  input  1  sole clock, rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port in_valid  input  1  input pixel present.
REQ-009 SHALL have port in_ready  output  1  block accepts a pixel this cycle.
REQ-010 SHALL have port color_mask  input  COLORS  per-color mask bit of the input pixel.
REQ-011 SHALL have port edge_in  input  1  edge bit of the input pixel.
REQ-012 SHALL have port out_valid  output  1  output pixel present, one-cycle pulse.
REQ-013 SHALL have port edge_color  output  COLORS  per-color merged edge bit.
REQ-014 SHALL have port edge_out  output  1  OR of edge_color.
REQ-015 SHALL have port out_row  output  clog2(HEIGHT)  row of the output pixel.
REQ-016 SHALL have port out_col  output  clog2(WIDTH)  column of the output pixel.
REQ-017 SHALL have port out_eof  output  1  high with out_valid on the last pixel of the frame.

Function
REQ-018 SHALL accept a pixel on any cycle with in_valid and in_ready both high; in_valid while in_ready is low SHALL be ignored.
REQ-019 SHALL process pixels in raster order, N = WIDTH*HEIGHT per frame, tracked by internal row and column counters.
REQ-020 SHALL implement FSM states FILL, STREAM, FLUSH.
REQ-021 FILL: in_ready=1, no output; after the (R*WIDTH+R)-th accepted pixel of the frame, SHALL move to STREAM.
REQ-022 STREAM: in_ready=1; after the N-th accepted pixel, SHALL move to FLUSH.
REQ-023 FLUSH: in_ready=0; SHALL inject one zero pixel per cycle, R*WIDTH+R cycles, then return to FILL with counters cleared.
REQ-024 SHALL set, for output pixel (r,c), count[k] = number of pixels with color_mask[k]=1 in rows r-R..r+R and columns c-R..c+R.
REQ-025 SHALL treat window positions outside the frame as zero, with no wrap across line ends and no wrap across frames.
REQ-026 SHALL set edge_color[k] = edge_in(r,c) AND (count[k] >= M_THRESHOLD).
REQ-027 SHALL use count width clog2(M_SIZE*M_SIZE+1), with no saturation or overflow.
REQ-028 SHALL emit output pixel j exactly 2 cycles after accepting (or injecting) input index j+R*WIDTH+R; injection cycles count as sources.
REQ-029 SHALL emit exactly N out_valid pulses per frame, j = 0..N-1 in raster order, with out_row/out_col = (j/WIDTH, j%WIDTH).
REQ-030 SHALL keep output content independent of idle gaps in in_valid; only timing shifts.
REQ-031 SHALL hold edge_color, edge_out, out_row, out_col and out_eof at 0 when out_valid=0.
REQ-032 SHALL use line storage of 2*R lines x (COLORS+1) bits, with column-sum and horizontal running-sum accumulators; a full 2-D window register array SHALL NOT be used.

Reset
REQ-033 SHALL, on reset assertion, immediately force out_valid, edge_color, edge_out, out_row, out_col, out_eof and in_ready to 0, set the FSM to FILL, and clear counters and accumulators.
REQ-034 SHALL set in_ready to 1 on the first clk edge after reset deasserts.
REQ-035 SHALL discard a frame interrupted by reset; the next accepted pixel is (0,0) of a new frame, with no stale line data contributing.

Verification
(Configuration: WIDTH=8, HEIGHT=6, M_SIZE=3, M_THRESHOLD=5, COLORS=2, R=1, fill/flush length 9.)
REQ-036 SHALL test: every pixel color_mask=01, edge=1, in_valid continuous -> corners 00 (count 4), non-corner border 01 (count 6), interior 01 (count 9), 48 pulses.
REQ-037 SHALL test: edge=1 everywhere, color_mask=00 -> 48 pulses, all edge_out=0, out_eof only on (5,7).
REQ-038 SHALL test, with M_THRESHOLD=3: color_mask=01 only at column 7, edge=1 -> (2,6)=01 and (2,0)=00, proving no line wrap.
REQ-039 SHALL test: after the 48th accepted pixel -> in_ready=0 for exactly 9 cycles; out_eof 2 cycles after the last injection; in_ready=1 next cycle.
REQ-040 SHALL test: random one-cycle in_valid gaps -> output sequence identical to the continuous run; the first out_valid occurs 2 cycles after the 10th accept.
REQ-041 SHALL test: reset asserted at pixel 20, then a full all-01 frame -> outputs match REQ-036 exactly, with no residue from the aborted frame.
